mem_port_arbiter: RTL and testbench

- Shares the single off-chip memory port between the I-cache refill path and the D-cache refill/write-back path of the 5-stage RISC-V pipeline.
- Grants one requester at a time and holds the grant until that requester's whole burst transaction completes.
- Forwards request, write-data and response handshakes between the granted cache and memory.
- Checks burst length and flags protocol violations.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/burst_beat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, grant sides
// and burst sizing defaults.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_REQ   = 3'd1,
    I_RD    = 3'd2,
    D_REQ   = 3'd3,
    D_RD    = 3'd4,
    D_WR    = 3'd5,
    D_WRESP = 3'd6
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEFAULT_BURST_LEN = 8;
  localparam int LEN_W             = 8;

endpackage

// File: rtl/burst_beat_counter.sv
// Counts transferred beats of a burst and flags the final beat.
// Shared by read and write bursts; clr wins over inc.
module burst_beat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [LEN_W-1:0] count,
  output logic             is_last
);

  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BURST_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == LAST_BEAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single off-chip memory port between the I-cache refill path
// and the D-cache refill/write-back path, holding the grant for a whole burst.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_last,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_wen,
  input  logic              d_wdata_valid,
  output logic              d_wdata_ready,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_wdata_last,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_last,
  output logic              d_wresp_valid,
  input  logic              d_wresp_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [LEN_W-1:0]  mem_req_len,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_last,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_last,
  input  logic              mem_wresp_valid,
  output logic              mem_wresp_ready,
  output logic              proto_err
);

  arb_state_t        state, state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic              grant_i, grant_d;
  logic              beat, beat_clr, err_set;
  logic [LEN_W-1:0]  beat_count;
  logic              beat_is_last;

  burst_beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (beat_clr),
    .inc     (beat),
    .count   (beat_count),
    .is_last (beat_is_last)
  );

  assign mem_req_addr = addr_q;
  assign mem_req_wen  = wen_q;
  assign mem_req_len  = LEN_W'(BURST_LEN - 1);
  assign i_resp_data  = mem_resp_data;
  assign d_resp_data  = mem_resp_data;
  assign mem_wdata    = d_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        addr_q     <= i_req_addr;
        wen_q      <= 1'b0;
        last_grant <= GRANT_I;
      end else if (grant_d) begin
        addr_q     <= d_req_addr;
        wen_q      <= d_req_wen;
        last_grant <= GRANT_D;
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Every channel is closed by default so an ungranted side never sees a handshake.
  always_comb begin
    state_next      = state;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    beat            = 1'b0;
    beat_clr        = 1'b0;
    err_set         = 1'b0;
    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    i_resp_valid    = 1'b0;
    i_resp_last     = 1'b0;
    d_resp_valid    = 1'b0;
    d_resp_last     = 1'b0;
    d_wdata_ready   = 1'b0;
    d_wresp_valid   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata_last  = 1'b0;
    mem_resp_ready  = 1'b0;
    mem_wresp_ready = 1'b0;

    case (state)
      IDLE: begin
        if (i_req_valid && (!d_req_valid || last_grant == GRANT_D)) begin
          grant_i     = 1'b1;
          i_req_ready = 1'b1;
          state_next  = I_REQ;
        end else if (d_req_valid) begin
          grant_d     = 1'b1;
          d_req_ready = 1'b1;
          state_next  = D_REQ;
        end
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = I_RD;
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = wen_q ? D_WR : D_RD;
      end
      I_RD: begin
        i_resp_valid   = mem_resp_valid;
        mem_resp_ready = i_resp_ready;
        i_resp_last    = beat_is_last;
        beat           = mem_resp_valid && i_resp_ready;
        err_set        = beat && (mem_resp_last != beat_is_last);
        if (beat && beat_is_last) begin
          beat_clr   = 1'b1;
          state_next = IDLE;
        end
      end
      D_RD: begin
        d_resp_valid   = mem_resp_valid;
        mem_resp_ready = d_resp_ready;
        d_resp_last    = beat_is_last;
        beat           = mem_resp_valid && d_resp_ready;
        err_set        = beat && (mem_resp_last != beat_is_last);
        if (beat && beat_is_last) begin
          beat_clr   = 1'b1;
          state_next = IDLE;
        end
      end
      D_WR: begin
        mem_wdata_valid = d_wdata_valid;
        d_wdata_ready   = mem_wdata_ready;
        mem_wdata_last  = beat_is_last;
        beat            = d_wdata_valid && mem_wdata_ready;
        err_set         = beat && (d_wdata_last != beat_is_last);
        if (beat && beat_is_last) begin
          beat_clr   = 1'b1;
          state_next = D_WRESP;
        end
      end
      D_WRESP: begin
        d_wresp_valid   = mem_wresp_valid;
        mem_wresp_ready = d_wresp_ready;
        if (mem_wresp_valid && d_wresp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with BURST_LEN = 8.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid, i_resp_ready, i_resp_last;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready, d_req_wen;
  logic [31:0] d_req_addr;
  logic        d_wdata_valid, d_wdata_ready, d_wdata_last;
  logic [31:0] d_wdata;
  logic        d_resp_valid, d_resp_ready, d_resp_last;
  logic [31:0] d_resp_data;
  logic        d_wresp_valid, d_wresp_ready;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [7:0]  mem_req_len;
  logic        mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_last;
  logic [31:0] mem_resp_data;
  logic        mem_wresp_valid, mem_wresp_ready;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_last(i_resp_last),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen),
    .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready), .d_wdata(d_wdata),
    .d_wdata_last(d_wdata_last),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_last(d_resp_last),
    .d_wresp_valid(d_wresp_valid), .d_wresp_ready(d_wresp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_len(mem_req_len),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
    .mem_wresp_valid(mem_wresp_valid), .mem_wresp_ready(mem_wresp_ready),
    .proto_err(proto_err)
  );

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = 0; i_req_addr = 0; i_resp_ready = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_wen = 0;
    d_wdata_valid = 0; d_wdata = 0; d_wdata_last = 0;
    d_resp_ready = 0; d_wresp_ready = 0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0; mem_resp_last = 0;
    mem_wresp_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d exp %0d", dut.state, IDLE); end
    checks++;
    if ({mem_req_valid, i_req_ready, d_req_ready, mem_resp_ready, mem_wresp_ready,
         mem_wdata_valid, i_resp_valid, d_resp_valid, d_wresp_valid} !== 9'b0) begin
      errors++; $display("[TB] FAIL reset_handshakes got nonzero exp all 0");
    end
    checks++;
    if (mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %0h exp 0", mem_req_addr); end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got %0b exp 0", proto_err); end
  endtask

  task automatic test_i_read();
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h1000;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL iread_grant got %0b exp 1", i_req_ready); end
    step();
    i_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if (i_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL iread_ready_pulse got %0b exp 0", i_req_ready); end
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len} !== {1'b1, 32'h1000, 1'b0, 8'd7}) begin
      errors++;
      $display("[TB] FAIL iread_mem_req got v%0b a%0h w%0b l%0d exp v1 a1000 w0 l7",
               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len);
    end
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 8; b++) begin
      mem_resp_valid = 1; mem_resp_data = 32'hA0 + b; mem_resp_last = (b == 7); i_resp_ready = 1;
      #1;
      checks++;
      if ({i_resp_valid, mem_resp_ready, i_resp_data, i_resp_last, d_resp_valid} !==
          {1'b1, 1'b1, 32'hA0 + b, (b == 7), 1'b0}) begin
        errors++;
        $display("[TB] FAIL iread_beat%0d got v%0b r%0b d%0h l%0b exp v1 r1 d%0h l%0b",
                 b, i_resp_valid, mem_resp_ready, i_resp_data, i_resp_last, 32'hA0 + b, (b == 7));
      end
      step();
    end
    mem_resp_valid = 1; mem_resp_last = 0;
    #1;
    checks++;
    if ({dut.state == IDLE, mem_resp_ready, i_resp_valid, proto_err} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL iread_end got idle%0b r%0b v%0b e%0b exp idle1 r0 v0 e0",
               dut.state == IDLE, mem_resp_ready, i_resp_valid, proto_err);
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_idle_stray();
    do_reset();
    mem_resp_valid = 1; mem_resp_last = 1; i_resp_ready = 1; d_resp_ready = 1;
    mem_wresp_valid = 1; d_wresp_ready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_resp_ready, mem_wresp_ready, i_resp_valid, d_resp_valid, d_wresp_valid} !== 5'b0 ||
          dut.beat_count !== 8'd0) begin
        errors++;
        $display("[TB] FAIL idle_stray c%0d got rr%0b wr%0b iv%0b dv%0b cnt%0d exp all 0",
                 c, mem_resp_ready, mem_wresp_ready, i_resp_valid, d_resp_valid, dut.beat_count);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h3000;
    d_req_valid = 1; d_req_addr = 32'h4000; d_req_wen = 0;
    #1;
    checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL rr_first_tie got d%0b i%0b exp d1 i0", d_req_ready, i_req_ready);
    end
    step();
    d_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, i_req_ready} !== {1'b1, 32'h4000, 1'b0}) begin
      errors++; $display("[TB] FAIL rr_d_req got v%0b a%0h ir%0b exp v1 a4000 ir0",
                         mem_req_valid, mem_req_addr, i_req_ready);
    end
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 8; b++) begin
      mem_resp_valid = 1; mem_resp_data = 32'hD0 + b; mem_resp_last = (b == 7); d_resp_ready = 1;
      #1;
      checks++;
      if ({d_resp_valid, d_resp_data, d_resp_last, i_resp_valid, i_req_ready} !==
          {1'b1, 32'hD0 + b, (b == 7), 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL rr_d_beat%0d got v%0b d%0h l%0b iv%0b ir%0b exp v1 d%0h l%0b iv0 ir0",
                 b, d_resp_valid, d_resp_data, d_resp_last, i_resp_valid, i_req_ready, 32'hD0 + b, (b == 7));
      end
      step();
    end
    mem_resp_valid = 0; mem_resp_last = 0; d_resp_ready = 0;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rr_pending_i got %0b exp 1", i_req_ready); end
    step();
    i_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if (mem_req_addr !== 32'h3000) begin errors++; $display("[TB] FAIL rr_i_addr got %0h exp 3000", mem_req_addr); end
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 8; b++) begin
      mem_resp_valid = 1; mem_resp_last = (b == 7); i_resp_ready = 1;
      step();
    end
    mem_resp_valid = 0; mem_resp_last = 0; i_resp_ready = 0;
    i_req_valid = 1; d_req_valid = 1;
    #1;
    checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL rr_second_tie got d%0b i%0b exp d1 i0", d_req_ready, i_req_ready);
    end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_proto_err got %0b exp 0", proto_err); end
    clear_inputs();
  endtask

  task automatic test_write_back();
    int b;
    int mcount;
    int cyc;
    bit dv, mr;
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h2000; d_req_wen = 1;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL wb_grant got %0b exp 1", d_req_ready); end
    step();
    d_req_valid = 0; d_req_wen = 0; mem_req_ready = 1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len} !== {1'b1, 32'h2000, 1'b1, 8'd7}) begin
      errors++; $display("[TB] FAIL wb_mem_req got v%0b a%0h w%0b l%0d exp v1 a2000 w1 l7",
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len);
    end
    step();
    mem_req_ready = 0;
    b = 0; mcount = 0; cyc = 0;
    while (b < 8 && cyc < 40) begin
      dv = (cyc != 1 && cyc != 6);
      mr = (cyc != 3 && cyc != 4);
      d_wdata_valid = dv; d_wdata = 32'hB0 + b; d_wdata_last = (b == 7); mem_wdata_ready = mr;
      #1;
      checks++;
      if ({mem_wdata_valid, d_wdata_ready, mem_wdata_last, d_wresp_valid} !== {dv, mr, (b == 7), 1'b0}) begin
        errors++;
        $display("[TB] FAIL wb_cyc%0d got v%0b r%0b l%0b wv%0b exp v%0b r%0b l%0b wv0",
                 cyc, mem_wdata_valid, d_wdata_ready, mem_wdata_last, d_wresp_valid, dv, mr, (b == 7));
      end
      if (mem_wdata_valid && mr) begin
        checks++;
        if (mem_wdata !== 32'hB0 + mcount) begin
          errors++; $display("[TB] FAIL wb_data%0d got %0h exp %0h", mcount, mem_wdata, 32'hB0 + mcount);
        end
        mcount++;
      end
      if (dv && mr) b++;
      cyc++;
      step();
    end
    checks++;
    if (mcount != 8 || cyc != 12) begin
      errors++; $display("[TB] FAIL wb_beats got %0d in %0d cycles exp 8 in 12", mcount, cyc);
    end
    d_wdata_valid = 0; d_wdata_last = 0; mem_wdata_ready = 1; d_wresp_ready = 1; mem_wresp_valid = 0;
    #1;
    checks++;
    if ({d_wresp_valid, mem_wresp_ready, mem_wdata_valid, d_wdata_ready} !== 4'b0100) begin
      errors++; $display("[TB] FAIL wb_wresp_wait got wv%0b wr%0b mv%0b dr%0b exp wv0 wr1 mv0 dr0",
                         d_wresp_valid, mem_wresp_ready, mem_wdata_valid, d_wdata_ready);
    end
    step();
    mem_wresp_valid = 1;
    #1;
    checks++;
    if (d_wresp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wb_wresp got %0b exp 1", d_wresp_valid); end
    step();
    #1;
    checks++;
    if ({dut.state == IDLE, d_wresp_valid, mem_wresp_ready, proto_err} !== 4'b1000) begin
      errors++; $display("[TB] FAIL wb_end got idle%0b wv%0b wr%0b e%0b exp idle1 wv0 wr0 e0",
                         dut.state == IDLE, d_wresp_valid, mem_wresp_ready, proto_err);
    end
    clear_inputs();
  endtask

  task automatic test_proto_err();
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h6000;
    step();
    i_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 8; b++) begin
      mem_resp_valid = 1; mem_resp_last = (b == 5); i_resp_ready = 1;
      #1;
      checks++;
      if ({i_resp_last, proto_err} !== {(b == 7), (b > 5)}) begin
        errors++; $display("[TB] FAIL perr_beat%0d got l%0b e%0b exp l%0b e%0b",
                           b, i_resp_last, proto_err, (b == 7), (b > 5));
      end
      step();
    end
    mem_resp_valid = 0; mem_resp_last = 0; i_resp_ready = 0;
    step();
    step();
    checks++;
    if ({dut.state == IDLE, proto_err} !== 2'b11) begin
      errors++; $display("[TB] FAIL perr_sticky got idle%0b e%0b exp idle1 e1", dut.state == IDLE, proto_err);
    end
    do_reset();
    #1;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL perr_clear got %0b exp 0", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h7000; d_req_wen = 0;
    step();
    d_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 3; b++) begin
      mem_resp_valid = 1; d_resp_ready = 1;
      step();
    end
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if ({dut.state == IDLE, d_resp_valid, mem_resp_ready, mem_req_valid} !== 4'b1000 ||
        dut.beat_count !== 8'd0) begin
      errors++; $display("[TB] FAIL rstmid got idle%0b dv%0b rr%0b mv%0b cnt%0d exp idle1 dv0 rr0 mv0 cnt0",
                         dut.state == IDLE, d_resp_valid, mem_resp_ready, mem_req_valid, dut.beat_count);
    end
    mem_resp_valid = 0; d_resp_ready = 0;
    i_req_valid = 1; i_req_addr = 32'h5000;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_regrant got %0b exp 1", i_req_ready); end
    step();
    i_req_valid = 0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h5000}) begin
      errors++; $display("[TB] FAIL rstmid_req got v%0b a%0h exp v1 a5000", mem_req_valid, mem_req_addr);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_i_read();
    test_idle_stray();
    test_round_robin();
    test_write_back();
    test_proto_err();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
